// File: rtl/qkv_attn_sequencer.sv
// Phase controller for the Q/K/V projection and attention datapath.
// Moore FSM with a per-phase saturating watchdog counter.
module qkv_attn_sequencer #(
    parameter int CNT_W      = 16,
    parameter int PROJ_LIMIT = 40000,
    parameter int ATTN_LIMIT = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             load_done,
    input  logic             finished_q,
    input  logic             finished_k,
    input  logic             finished_v,
    input  logic             attn_done,
    input  logic             readout_done,
    input  logic             abort,
    output logic             init,
    output logic             en,
    output logic             attn_start,
    output logic [1:0]       mem_sel,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PROJ    = 3'd2,
        S_ATTN_GO = 3'd3,
        S_ATTN    = 3'd4,
        S_READOUT = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PROJ_TC = CNT_W'(PROJ_LIMIT - 1);
    localparam logic [CNT_W-1:0] ATTN_TC = CNT_W'(ATTN_LIMIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             fq_q, fq_d, fk_q, fk_d, fv_q, fv_d;
    logic             done_q, done_d;
    logic             proj_exit;
    logic             in_proj, in_attn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= '0;
            fq_q      <= 1'b0;
            fk_q      <= 1'b0;
            fv_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            fq_q      <= fq_d;
            fk_q      <= fk_d;
            fv_q      <= fv_d;
            done_q    <= done_d;
        end
    end

    assign in_proj   = (state_q == S_PROJ);
    assign in_attn   = (state_q == S_ATTN);
    // A finish arriving in the same cycle as the last sticky flag still counts.
    assign proj_exit = (fq_q | finished_q) & (fk_q | finished_k) & (fv_q | finished_v);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (go && !abort) state_d = S_LOAD;
            S_LOAD:    if (load_done) state_d = S_PROJ;
            S_PROJ: begin
                if (proj_exit)                 state_d = S_ATTN_GO;
                else if (cyc_cnt_q == PROJ_TC) state_d = S_ERR;
            end
            S_ATTN_GO: state_d = S_ATTN;
            S_ATTN: begin
                if (attn_done)                 state_d = S_READOUT;
                else if (cyc_cnt_q == ATTN_TC) state_d = S_ERR;
            end
            S_READOUT: if (readout_done) state_d = S_IDLE;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        done_d = (state_q == S_READOUT) && readout_done && !abort;
        // Flags only live inside PROJ, so they are already clear on entry.
        fq_d = in_proj && !abort && (fq_q | finished_q);
        fk_d = in_proj && !abort && (fk_q | finished_k);
        fv_d = in_proj && !abort && (fv_q | finished_v);
        cyc_cnt_d = cyc_cnt_q;
        if ((state_d != state_q) || !(in_proj || in_attn)) cyc_cnt_d = '0;
        else if (cyc_cnt_q != '1)                         cyc_cnt_d = cyc_cnt_q + 1'b1;
    end

    always_comb begin
        init        = (state_q == S_LOAD);
        en          = in_proj;
        attn_start  = (state_q == S_ATTN_GO);
        busy        = (state_q != S_IDLE);
        timeout_err = (state_q == S_ERR);
        case (state_q)
            S_LOAD, S_READOUT:  mem_sel = 2'd2;
            S_PROJ:             mem_sel = 2'd0;
            S_ATTN_GO, S_ATTN:  mem_sel = 2'd1;
            default:            mem_sel = 2'd3;
        endcase
    end

    assign done    = done_q;
    assign state   = state_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_qkv_attn_sequencer.sv
// Directed self-checking bench for qkv_attn_sequencer; a second instance
// with short limits exercises the watchdog paths.
module tb_qkv_attn_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 0, load_done = 0, finished_q = 0, finished_k = 0, finished_v = 0;
    logic attn_done = 0, readout_done = 0, abort = 0;

    logic        init, en, attn_start, busy, done, timeout_err;
    logic [1:0]  mem_sel;
    logic [2:0]  state;
    logic [15:0] cyc_cnt;

    logic        t_init, t_en, t_attn_start, t_busy, t_done, t_timeout_err;
    logic [1:0]  t_mem_sel;
    logic [2:0]  t_state;
    logic [15:0] t_cyc_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    qkv_attn_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .load_done(load_done),
        .finished_q(finished_q), .finished_k(finished_k), .finished_v(finished_v),
        .attn_done(attn_done), .readout_done(readout_done), .abort(abort),
        .init(init), .en(en), .attn_start(attn_start), .mem_sel(mem_sel),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .state(state), .cyc_cnt(cyc_cnt)
    );

    qkv_attn_sequencer #(.CNT_W(16), .PROJ_LIMIT(8), .ATTN_LIMIT(6)) dut_t (
        .clk(clk), .rst(rst), .go(go), .load_done(load_done),
        .finished_q(finished_q), .finished_k(finished_k), .finished_v(finished_v),
        .attn_done(attn_done), .readout_done(readout_done), .abort(abort),
        .init(t_init), .en(t_en), .attn_start(t_attn_start), .mem_sel(t_mem_sel),
        .busy(t_busy), .done(t_done), .timeout_err(t_timeout_err),
        .state(t_state), .cyc_cnt(t_cyc_cnt)
    );

    always @(negedge clk) begin
        if (attn_start) n_start++;
        if (done)       n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_sel", 32'(mem_sel), 3);
        chk("rst_outs", {init, en, attn_start, busy, done, timeout_err}, 0);
        chk("rst_cyc", 32'(cyc_cnt), 0);
        rst = 1'b0;
        tick();
        chk("idle_state", 32'(state), 0);

        // T1 full run
        go = 1; tick(); go = 0;
        chk("t1_load_state", 32'(state), 1);
        chk("t1_load_outs", {init, en, busy, mem_sel}, 5'b10110);
        repeat (4) tick();
        chk("t1_load_hold", 32'(state), 1);
        load_done = 1; tick(); load_done = 0;
        chk("t1_proj_state", 32'(state), 2);
        chk("t1_proj_outs", {init, en, mem_sel}, 4'b0100);
        chk("t1_proj_cyc0", 32'(cyc_cnt), 0);
        tick(); tick();
        chk("t1_proj_cyc2", 32'(cyc_cnt), 2);
        finished_q = 1; finished_k = 1; finished_v = 1; tick();
        finished_q = 0; finished_k = 0; finished_v = 0;
        chk("t1_attngo_state", 32'(state), 3);
        chk("t1_attngo_outs", {attn_start, en, mem_sel}, 4'b1001);
        chk("t1_attngo_cyc", 32'(cyc_cnt), 0);
        tick();
        chk("t1_attn_state", 32'(state), 4);
        chk("t1_attn_start_low", 32'(attn_start), 0);
        repeat (9) tick();
        chk("t1_attn_cyc9", 32'(cyc_cnt), 9);
        attn_done = 1; tick(); attn_done = 0;
        chk("t1_readout_state", 32'(state), 5);
        chk("t1_readout_mem", 32'(mem_sel), 2);
        readout_done = 1; tick(); readout_done = 0;
        chk("t1_done_state", 32'(state), 0);
        chk("t1_done_outs", {done, busy, mem_sel}, 4'b1011);
        tick();
        chk("t1_done_pulse_end", 32'(done), 0);
        chk("t1_n_start", 32'(n_start), 1);
        chk("t1_n_done", 32'(n_done), 1);

        // go with abort in IDLE stays in IDLE (also clears dut_t)
        go = 1; abort = 1; tick(); go = 0; abort = 0;
        chk("go_abort_idle", 32'(state), 0);
        chk("t_idle_after_abort", 32'(t_state), 0);

        // T2 staggered finishes
        go = 1; tick(); go = 0;
        load_done = 1; tick(); load_done = 0;
        chk("t2_proj_state", 32'(state), 2);
        for (int c = 0; c <= 40; c++) begin
            finished_k = (c == 10);
            finished_v = (c == 25);
            finished_q = (c == 40);
            chk($sformatf("t2_en_c%0d", c), {en, state}, {1'b1, 3'd2});
            chk($sformatf("t2_cyc_c%0d", c), 32'(cyc_cnt), 32'(c));
            tick();
        end
        finished_q = 0; finished_k = 0; finished_v = 0;
        chk("t2_attngo_at_41", 32'(state), 3);
        attn_done = 1; tick(); attn_done = 0;
        chk("t2_attngo_ignores_done", 32'(state), 4);

        // T5 abort during ATTN, stale finishes must not pre-set flags
        finished_q = 1; finished_k = 1; finished_v = 1;
        abort = 1; tick(); abort = 0;
        chk("t5_abort_state", 32'(state), 0);
        chk("t5_abort_no_done", {done, busy}, 0);
        go = 1; tick(); go = 0;
        chk("t5_load", 32'(state), 1);
        load_done = 1; tick(); load_done = 0;
        chk("t5_proj", 32'(state), 2);
        finished_q = 0; finished_k = 0; finished_v = 0;
        tick();
        chk("t5_flags_not_preset", 32'(state), 2);
        chk("t5_cyc1", 32'(cyc_cnt), 1);
        abort = 1; tick(); abort = 0;
        chk("t5_abort2", 32'(state), 0);
        chk("t5_abort2_t", 32'(t_state), 0);
        chk("t5_n_done", 32'(n_done), 1);

        // T3 PROJ timeout with PROJ_LIMIT=8
        go = 1; tick(); go = 0;
        load_done = 1; tick(); load_done = 0;
        chk("t3_proj", 32'(t_state), 2);
        for (int c = 0; c < 8; c++) begin
            finished_q = (c == 0);
            chk($sformatf("t3_in_proj_c%0d", c), 32'(t_state), 2);
            tick();
        end
        finished_q = 0;
        chk("t3_err_state", 32'(t_state), 6);
        chk("t3_err_outs", {t_timeout_err, t_en, t_busy, t_mem_sel}, 5'b10111);
        chk("t3_err_cyc", 32'(t_cyc_cnt), 0);
        go = 1; tick(); tick(); go = 0;
        chk("t3_err_sticky", 32'(t_state), 6);
        abort = 1; tick(); abort = 0;
        chk("t3_abort_state", 32'(t_state), 0);
        chk("t3_abort_terr", 32'(t_timeout_err), 0);

        // T4 last finish on cyc_cnt==LIMIT-1, then ATTN timeout
        go = 1; tick(); go = 0;
        load_done = 1; tick(); load_done = 0;
        for (int c = 0; c < 8; c++) begin
            finished_k = (c == 2);
            finished_v = (c == 5);
            finished_q = (c == 7);
            if (c == 7) chk("t4_cyc_tc", 32'(t_cyc_cnt), 7);
            tick();
        end
        finished_q = 0; finished_k = 0; finished_v = 0;
        chk("t4_tie_attngo", 32'(t_state), 3);
        tick();
        chk("t4_attn", 32'(t_state), 4);
        repeat (5) tick();
        chk("t4_attn_cyc5", {t_state, t_cyc_cnt}, {3'd4, 16'd5});
        tick();
        chk("t4_attn_timeout", 32'(t_state), 6);
        abort = 1; tick(); abort = 0;
        chk("t4_abort", {state, t_state}, 0);

        // T6 async reset mid-PROJ
        go = 1; tick(); go = 0;
        load_done = 1; tick(); load_done = 0;
        tick(); tick();
        chk("t6_proj_cyc2", {state, cyc_cnt}, {3'd2, 16'd2});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_outs", {init, en, attn_start, busy, done, timeout_err}, 0);
        chk("t6_rst_mem_cyc", {mem_sel, cyc_cnt}, {2'd3, 16'd0});
        #2 rst = 1'b0;
        go = 1; tick(); go = 0;
        chk("t6_go_after_release", 32'(state), 1);
        abort = 1; tick(); abort = 0;
        chk("final_n_start", 32'(n_start), 3);
        chk("final_n_done", 32'(n_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
